// File: rtl/hazard_controller_if.sv
// hazard_controller_if: bundles the hazard inputs from the pipeline stages,
// the per-register load/flush controls and the performance counter outputs.
// The pipeline side uses the master modport; the controller uses slave.
interface hazard_controller_if #(
  parameter int width = 32
);
  logic [4:0]       IF_ID_rs1_i;
  logic [4:0]       IF_ID_rs2_i;
  logic             IF_ID_use_rs1_i;
  logic             IF_ID_use_rs2_i;
  logic [4:0]       ID_EX_rd_i;
  logic             ID_EX_mem_read_i;
  logic             EX_branch_taken_i;
  logic             imem_resp_i;
  logic             dmem_req_i;
  logic             dmem_resp_i;
  logic             pc_load_o;
  logic             IF_ID_load_o;
  logic             ID_EX_load_o;
  logic             EX_MEM_load_o;
  logic             MEM_WB_load_o;
  logic             IF_ID_flush_o;
  logic             ID_EX_flush_o;
  logic [width-1:0] stall_cycles_o;
  logic [width-1:0] bubble_count_o;
  logic [width-1:0] flush_count_o;

  modport master (
    output IF_ID_rs1_i, IF_ID_rs2_i, IF_ID_use_rs1_i, IF_ID_use_rs2_i,
           ID_EX_rd_i, ID_EX_mem_read_i, EX_branch_taken_i,
           imem_resp_i, dmem_req_i, dmem_resp_i,
    input  pc_load_o, IF_ID_load_o, ID_EX_load_o, EX_MEM_load_o, MEM_WB_load_o,
           IF_ID_flush_o, ID_EX_flush_o,
           stall_cycles_o, bubble_count_o, flush_count_o
  );

  modport slave (
    input  IF_ID_rs1_i, IF_ID_rs2_i, IF_ID_use_rs1_i, IF_ID_use_rs2_i,
           ID_EX_rd_i, ID_EX_mem_read_i, EX_branch_taken_i,
           imem_resp_i, dmem_req_i, dmem_resp_i,
    output pc_load_o, IF_ID_load_o, ID_EX_load_o, EX_MEM_load_o, MEM_WB_load_o,
           IF_ID_flush_o, ID_EX_flush_o,
           stall_cycles_o, bubble_count_o, flush_count_o
  );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller: per-cycle pipeline register load/flush decode covering
// load-use bubbles, taken-branch flushes and memory freezes.
// Optional feature: define HAZARD_PERF_EN to build the saturating performance
// counters; otherwise the counter outputs are tied to zero.
// The width parameter must match the width of the connected interface.
module hazard_controller #(
  parameter int width = 32
) (
  input  logic               clk,
  input  logic               rst,
  hazard_controller_if.slave hz
);

  typedef enum logic [1:0] {RUN, LU_BUBBLE, FROZEN} state_t;

  state_t state_q, state_d;
  logic   flush_pending_q, flush_pending_d;
  // Set when a freeze interrupts the bubble cycle, so the same hazard is not
  // bubbled a second time once the freeze ends.
  logic   bubble_mask_q, bubble_mask_d;

  logic       freeze;
  logic       lu_hazard;
  logic       flush_req;
  logic       lu_armed;
  logic       do_flush;
  logic       do_bubble;
  logic [6:0] ctrl;

  // Raw hazard conditions from the stage inputs.
  always_comb begin
    freeze    = (hz.dmem_req_i & ~hz.dmem_resp_i) | ~hz.imem_resp_i;
    lu_hazard = hz.ID_EX_mem_read_i & (|hz.ID_EX_rd_i) &
                ((hz.IF_ID_use_rs1_i & (hz.ID_EX_rd_i == hz.IF_ID_rs1_i)) |
                 (hz.IF_ID_use_rs2_i & (hz.ID_EX_rd_i == hz.IF_ID_rs2_i)));
    flush_req = hz.EX_branch_taken_i | flush_pending_q;
    lu_armed  = (state_q == RUN) | ((state_q == FROZEN) & ~bubble_mask_q);
  end

  // Priority decode: freeze, then flush, then load-use, then normal flow.
  // ctrl = {pc, IF_ID, ID_EX, EX_MEM, MEM_WB loads, IF_ID flush, ID_EX flush}.
  always_comb begin
    state_d         = state_q;
    flush_pending_d = flush_pending_q;
    bubble_mask_d   = bubble_mask_q;
    do_flush        = 1'b0;
    do_bubble       = 1'b0;
    ctrl            = 7'b00000_00;
    if (freeze) begin
      state_d = FROZEN;
      if (hz.EX_branch_taken_i) flush_pending_d = 1'b1;
      if (state_q == LU_BUBBLE) bubble_mask_d = 1'b1;
    end else if (flush_req) begin
      ctrl            = 7'b11111_11;
      flush_pending_d = 1'b0;
      bubble_mask_d   = 1'b0;
      state_d         = RUN;
      do_flush        = 1'b1;
    end else if (lu_hazard && lu_armed) begin
      ctrl          = 7'b00111_01;
      bubble_mask_d = 1'b0;
      state_d       = LU_BUBBLE;
      do_bubble     = 1'b1;
    end else begin
      ctrl          = 7'b11111_00;
      bubble_mask_d = 1'b0;
      state_d       = RUN;
    end
    if (rst) ctrl = 7'b00000_00;
  end

  assign hz.pc_load_o     = ctrl[6];
  assign hz.IF_ID_load_o  = ctrl[5];
  assign hz.ID_EX_load_o  = ctrl[4];
  assign hz.EX_MEM_load_o = ctrl[3];
  assign hz.MEM_WB_load_o = ctrl[2];
  assign hz.IF_ID_flush_o = ctrl[1];
  assign hz.ID_EX_flush_o = ctrl[0];

  // State, pending-flush and bubble-mask registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= RUN;
      flush_pending_q <= 1'b0;
      bubble_mask_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      flush_pending_q <= flush_pending_d;
      bubble_mask_q   <= bubble_mask_d;
    end
  end

`ifdef HAZARD_PERF_EN
  localparam logic [width-1:0] cnt_one = width'(1);
  localparam logic [width-1:0] cnt_max = '1;

  logic [width-1:0] stall_cycles_q, stall_cycles_d;
  logic [width-1:0] bubble_count_q, bubble_count_d;
  logic [width-1:0] flush_count_q,  flush_count_d;

  // Saturating event counters.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    bubble_count_d = bubble_count_q;
    flush_count_d  = flush_count_q;
    if (freeze && stall_cycles_q != cnt_max) stall_cycles_d = stall_cycles_q + cnt_one;
    if (do_bubble && bubble_count_q != cnt_max) bubble_count_d = bubble_count_q + cnt_one;
    if (do_flush && flush_count_q != cnt_max) flush_count_d = flush_count_q + cnt_one;
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      bubble_count_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      bubble_count_q <= bubble_count_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign hz.stall_cycles_o = stall_cycles_q;
  assign hz.bubble_count_o = bubble_count_q;
  assign hz.flush_count_o  = flush_count_q;
`else
  assign hz.stall_cycles_o = '0;
  assign hz.bubble_count_o = '0;
  assign hz.flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed scenarios for hazard_controller with
// hand-computed expected load/flush vectors and counter values.
module tb_hazard_controller;

`ifdef HAZARD_PERF_EN
  localparam int perf = 1;
`else
  localparam int perf = 0;
`endif

  localparam logic [6:0] OUT_ZERO   = 7'b00000_00;
  localparam logic [6:0] OUT_NORMAL = 7'b11111_00;
  localparam logic [6:0] OUT_FLUSH  = 7'b11111_11;
  localparam logic [6:0] OUT_LU     = 7'b00111_01;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  hazard_controller_if #(.width(32)) hz ();

  hazard_controller #(.width(32)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  logic [6:0] outs;
  assign outs = {hz.pc_load_o, hz.IF_ID_load_o, hz.ID_EX_load_o, hz.EX_MEM_load_o,
                 hz.MEM_WB_load_o, hz.IF_ID_flush_o, hz.ID_EX_flush_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    hz.IF_ID_rs1_i       = 5'd0;
    hz.IF_ID_rs2_i       = 5'd0;
    hz.IF_ID_use_rs1_i   = 1'b0;
    hz.IF_ID_use_rs2_i   = 1'b0;
    hz.ID_EX_rd_i        = 5'd0;
    hz.ID_EX_mem_read_i  = 1'b0;
    hz.EX_branch_taken_i = 1'b0;
    hz.imem_resp_i       = 1'b1;
    hz.dmem_req_i        = 1'b0;
    hz.dmem_resp_i       = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    rst = 1'b0;
  endtask

  task automatic set_lu_rs2();
    hz.ID_EX_mem_read_i = 1'b1;
    hz.ID_EX_rd_i       = 5'd5;
    hz.IF_ID_rs2_i      = 5'd5;
    hz.IF_ID_use_rs2_i  = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #2;
    total++;
    if (outs !== OUT_ZERO) begin bad++; $display("[TB] FAIL reset_outs got=%b exp=%b", outs, OUT_ZERO); end
    step();
    rst = 1'b0;
    #2;
    total++;
    if (outs !== OUT_NORMAL) begin bad++; $display("[TB] FAIL reset_release got=%b exp=%b", outs, OUT_NORMAL); end
    total++;
    if ((hz.stall_cycles_o | hz.bubble_count_o | hz.flush_count_o) !== 32'd0) begin
      bad++; $display("[TB] FAIL reset_counters got=%0d/%0d/%0d exp=0", hz.stall_cycles_o, hz.bubble_count_o, hz.flush_count_o);
    end
    step();
  endtask

  task automatic test_load_use();
    do_reset();
    set_lu_rs2();
    #2;
    total++;
    if (outs !== OUT_LU) begin bad++; $display("[TB] FAIL lu_stall got=%b exp=%b", outs, OUT_LU); end
    step();
    #2;
    total++;
    if (outs !== OUT_NORMAL) begin bad++; $display("[TB] FAIL lu_bubble_cycle got=%b exp=%b", outs, OUT_NORMAL); end
    total++;
    if (hz.bubble_count_o !== 32'(perf)) begin bad++; $display("[TB] FAIL lu_bubble_count got=%0d exp=%0d", hz.bubble_count_o, perf); end
    step();
    idle_inputs();
    #2;
    total++;
    if (outs !== OUT_NORMAL) begin bad++; $display("[TB] FAIL lu_resume got=%b exp=%b", outs, OUT_NORMAL); end
    total++;
    if (hz.bubble_count_o !== 32'(perf)) begin bad++; $display("[TB] FAIL lu_bubble_once got=%0d exp=%0d", hz.bubble_count_o, perf); end
    step();
  endtask

  task automatic test_x0_unused();
    do_reset();
    hz.ID_EX_mem_read_i = 1'b1;
    hz.ID_EX_rd_i       = 5'd0;
    hz.IF_ID_rs1_i      = 5'd0;
    hz.IF_ID_use_rs1_i  = 1'b1;
    #2;
    total++;
    if (outs !== OUT_NORMAL) begin bad++; $display("[TB] FAIL x0_no_stall got=%b exp=%b", outs, OUT_NORMAL); end
    step();
    hz.ID_EX_rd_i      = 5'd7;
    hz.IF_ID_rs1_i     = 5'd7;
    hz.IF_ID_use_rs1_i = 1'b0;
    hz.IF_ID_rs2_i     = 5'd3;
    hz.IF_ID_use_rs2_i = 1'b1;
    #2;
    total++;
    if (outs !== OUT_NORMAL) begin bad++; $display("[TB] FAIL unused_rs1_no_stall got=%b exp=%b", outs, OUT_NORMAL); end
    hz.IF_ID_use_rs1_i = 1'b1;
    #1;
    total++;
    if (outs !== OUT_LU) begin bad++; $display("[TB] FAIL rs1_match_stall got=%b exp=%b", outs, OUT_LU); end
    step();
  endtask

  task automatic test_branch_lu();
    do_reset();
    set_lu_rs2();
    hz.EX_branch_taken_i = 1'b1;
    #2;
    total++;
    if (outs !== OUT_FLUSH) begin bad++; $display("[TB] FAIL branch_lu_flush got=%b exp=%b", outs, OUT_FLUSH); end
    step();
    idle_inputs();
    #2;
    total++;
    if (outs !== OUT_NORMAL) begin bad++; $display("[TB] FAIL branch_after got=%b exp=%b", outs, OUT_NORMAL); end
    total++;
    if (hz.bubble_count_o !== 32'd0) begin bad++; $display("[TB] FAIL branch_lu_bubbles got=%0d exp=0", hz.bubble_count_o); end
    total++;
    if (hz.flush_count_o !== 32'(perf)) begin bad++; $display("[TB] FAIL branch_lu_flushes got=%0d exp=%0d", hz.flush_count_o, perf); end
    step();
  endtask

  task automatic test_branch_freeze();
    do_reset();
    hz.dmem_req_i        = 1'b1;
    hz.dmem_resp_i       = 1'b0;
    hz.EX_branch_taken_i = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      #2;
      total++;
      if (outs !== OUT_ZERO) begin bad++; $display("[TB] FAIL freeze_cycle%0d got=%b exp=%b", c, outs, OUT_ZERO); end
      step();
      hz.EX_branch_taken_i = 1'b0;
    end
    hz.dmem_resp_i = 1'b1;
    #2;
    total++;
    if (outs !== OUT_FLUSH) begin bad++; $display("[TB] FAIL freeze_release_flush got=%b exp=%b", outs, OUT_FLUSH); end
    step();
    idle_inputs();
    #2;
    total++;
    if (outs !== OUT_NORMAL) begin bad++; $display("[TB] FAIL freeze_single_flush got=%b exp=%b", outs, OUT_NORMAL); end
    total++;
    if (hz.stall_cycles_o !== 32'(3 * perf)) begin bad++; $display("[TB] FAIL freeze_stall_count got=%0d exp=%0d", hz.stall_cycles_o, 3 * perf); end
    total++;
    if (hz.flush_count_o !== 32'(perf)) begin bad++; $display("[TB] FAIL freeze_flush_count got=%0d exp=%0d", hz.flush_count_o, perf); end
    step();
  endtask

  task automatic test_fetch_stall();
    do_reset();
    hz.imem_resp_i = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      #2;
      total++;
      if (outs !== OUT_ZERO) begin bad++; $display("[TB] FAIL fetch_stall%0d got=%b exp=%b", c, outs, OUT_ZERO); end
      step();
    end
    hz.imem_resp_i = 1'b1;
    #2;
    total++;
    if (outs !== OUT_NORMAL) begin bad++; $display("[TB] FAIL fetch_resume got=%b exp=%b", outs, OUT_NORMAL); end
    total++;
    if (hz.stall_cycles_o !== 32'(2 * perf)) begin bad++; $display("[TB] FAIL fetch_stall_count got=%0d exp=%0d", hz.stall_cycles_o, 2 * perf); end
    step();
  endtask

  task automatic test_freeze_lu();
    do_reset();
    set_lu_rs2();
    hz.dmem_req_i  = 1'b1;
    hz.dmem_resp_i = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      #2;
      total++;
      if (outs !== OUT_ZERO) begin bad++; $display("[TB] FAIL frz_lu_hold%0d got=%b exp=%b", c, outs, OUT_ZERO); end
      step();
    end
    hz.dmem_resp_i = 1'b1;
    #2;
    total++;
    if (outs !== OUT_LU) begin bad++; $display("[TB] FAIL frz_lu_after got=%b exp=%b", outs, OUT_LU); end
    step();
    hz.dmem_req_i  = 1'b0;
    hz.dmem_resp_i = 1'b0;
    #2;
    total++;
    if (outs !== OUT_NORMAL) begin bad++; $display("[TB] FAIL frz_lu_once got=%b exp=%b", outs, OUT_NORMAL); end
    total++;
    if (hz.bubble_count_o !== 32'(perf)) begin bad++; $display("[TB] FAIL frz_lu_bubbles got=%0d exp=%0d", hz.bubble_count_o, perf); end
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    hz.dmem_req_i        = 1'b1;
    hz.dmem_resp_i       = 1'b0;
    hz.EX_branch_taken_i = 1'b1;
    step();
    idle_inputs();
    #2;
    total++;
    if (outs !== OUT_FLUSH) begin bad++; $display("[TB] FAIL pending_visible got=%b exp=%b", outs, OUT_FLUSH); end
    rst = 1'b1;
    #1;
    total++;
    if (outs !== OUT_ZERO) begin bad++; $display("[TB] FAIL rst_async_outs got=%b exp=%b", outs, OUT_ZERO); end
    #1;
    rst = 1'b0;
    #1;
    total++;
    if (outs !== OUT_NORMAL) begin bad++; $display("[TB] FAIL rst_drops_pending got=%b exp=%b", outs, OUT_NORMAL); end
    total++;
    if ((hz.stall_cycles_o | hz.flush_count_o) !== 32'd0) begin
      bad++; $display("[TB] FAIL rst_clears_counters got=%0d/%0d exp=0", hz.stall_cycles_o, hz.flush_count_o);
    end
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_x0_unused();
    test_branch_lu();
    test_branch_freeze();
    test_fetch_stall();
    test_freeze_lu();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
